// File: rtl/multi_channel_pwm_pkg.sv
// Shared defaults, run-mode encoding and the register-file layout that feeds
// the cfg_* ports of the multi-channel PWM core.
package multi_channel_pwm_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_PRE_W  = 8;

  // Byte offsets and field positions inside the AXI-Lite register file.
  localparam int REG_CTRL_OFS      = 'h00;
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int REG_PERIOD_OFS    = 'h04;
  localparam int PERIOD_LSB        = 0;
  localparam int REG_CHCFG_OFS     = 'h08;
  localparam int CHCFG_EN_LSB      = 0;
  localparam int CHCFG_POL_LSB     = 16;
  localparam int REG_DUTY0_OFS     = 'h10;
  localparam int DUTY_LSB          = 0;

  typedef enum logic {
    MODE_IDLE = 1'b0,
    MODE_RUN  = 1'b1
  } pwm_mode_e;

  function automatic int duty_reg_ofs(input int ch);
    return REG_DUTY0_OFS + 4 * ch;
  endfunction

endpackage

// File: rtl/multi_channel_pwm_core_compare.sv
// One PWM channel: shadowed duty/enable/polarity, counter compare and the
// registered output.
module pwm_compare_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] counter,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic             cfg_en,
  input  logic             cfg_pol,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic             en_q, en_d;
  logic             pol_q, pol_d;
  logic             out_q, out_d;

  always_comb begin
    duty_d = duty_q;
    en_d   = en_q;
    pol_d  = pol_q;
    if (load) begin
      duty_d = cfg_duty;
      en_d   = cfg_en;
      pol_d  = cfg_pol;
    end
    // Idle parks the pin at its inactive level.
    out_d = pol_q;
    if (run) begin
      out_d = (en_q & (counter < duty_q)) ^ pol_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      en_q   <= 1'b0;
      pol_q  <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      en_q   <= en_d;
      pol_q  <= pol_d;
      out_q  <= out_d;
    end
  end

  assign pwm_out = out_q;

endmodule

// File: rtl/multi_channel_pwm_core.sv
// Multi-channel PWM core: shared prescaler and period counter, shadowed
// configuration that only changes at a period boundary.
module multi_channel_pwm_core
  import multi_channel_pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PRE_W  = DEF_PRE_W
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    cfg_enable,
  input  logic [PRE_W-1:0]        cfg_prescale,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
  input  logic [NUM_CH-1:0]       cfg_ch_en,
  input  logic [NUM_CH-1:0]       cfg_polarity,
  input  logic                    cfg_update,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_end,
  output logic                    update_pending
);

  pwm_mode_e        mode;
  logic             run, tick, wrap, load;
  logic [PRE_W-1:0] presc_q, presc_d, pre_sh_q, pre_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_sh_q, per_sh_d;
  logic             pend_q, pend_d;
  logic             pe_q, pe_d;

  always_comb begin
    mode = cfg_enable ? MODE_RUN : MODE_IDLE;
    run  = (mode == MODE_RUN);
    tick = run && (presc_q == pre_sh_q);
    wrap = tick && (cnt_q == per_sh_q);
    // Idle tracks cfg_* continuously; running only swaps at a wrap, either
    // from an earlier pending strobe or one landing on the wrap itself.
    load = !run || (wrap && (pend_q || cfg_update));

    presc_d  = '0;
    cnt_d    = '0;
    pend_d   = 1'b0;
    pe_d     = wrap;
    pre_sh_d = load ? cfg_prescale : pre_sh_q;
    per_sh_d = load ? cfg_period   : per_sh_q;
    if (run) begin
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
      cnt_d   = cnt_q;
      if (tick) begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      pend_d = !wrap && (pend_q || cfg_update);
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      pre_sh_q <= '0;
      per_sh_q <= '0;
      pend_q   <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      pre_sh_q <= pre_sh_d;
      per_sh_q <= per_sh_d;
      pend_q   <= pend_d;
      pe_q     <= pe_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_compare_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .run      (run),
      .load     (load),
      .counter  (cnt_q),
      .cfg_duty (cfg_duty[i*CNT_W +: CNT_W]),
      .cfg_en   (cfg_ch_en[i]),
      .cfg_pol  (cfg_polarity[i]),
      .pwm_out  (pwm_out[i])
    );
  end

  assign period_end     = pe_q;
  assign update_pending = pend_q;

endmodule

// File: tb/tb_multi_channel_pwm_core.sv
// Bench for multi_channel_pwm_core: table of per-period vectors, hand-written
// update/reset sequences and randomized traffic against a position-in-period model.
module tb_multi_channel_pwm_core;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PRE_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cfg_enable = 1'b0;
  logic [PRE_W-1:0]        cfg_prescale = '0;
  logic [CNT_W-1:0]        cfg_period = '0;
  logic [NUM_CH*CNT_W-1:0] cfg_duty = '0;
  logic [NUM_CH-1:0]       cfg_ch_en = '0;
  logic [NUM_CH-1:0]       cfg_polarity = '0;
  logic                    cfg_update = 1'b0;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_end;
  logic                    update_pending;

  int n_pass = 0;
  int n_total = 0;

  multi_channel_pwm_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .cfg_enable     (cfg_enable),
    .cfg_prescale   (cfg_prescale),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .cfg_ch_en      (cfg_ch_en),
    .cfg_polarity   (cfg_polarity),
    .cfg_update     (cfg_update),
    .pwm_out        (pwm_out),
    .period_end     (period_end),
    .update_pending (update_pending)
  );

  // ---------------- clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "bench timeout");
  end

  // ---------------- next configuration to drive
  logic              nx_enable;
  int                nx_pre, nx_per;
  int                nx_duty [NUM_CH];
  logic [NUM_CH-1:0] nx_en, nx_pol;

  // ---------------- reference model: clocks elapsed in the current period
  int                m_pre, m_per, m_pos;
  int                m_duty [NUM_CH];
  logic [NUM_CH-1:0] m_en, m_pol, m_out;
  logic              m_pe, m_pend;

  logic [NUM_CH-1:0] s_out;
  logic              s_pe, s_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pre = 0; m_per = 0; m_pos = 0;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
    m_en = '0; m_pol = '0; m_out = '0; m_pe = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_load();
    m_pre = int'(cfg_prescale);
    m_per = int'(cfg_period);
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(cfg_duty[i*CNT_W +: CNT_W]);
    m_en  = cfg_ch_en;
    m_pol = cfg_polarity;
  endtask

  // Advance one clock: outputs of the next cycle from the inputs of this one.
  task automatic model_step();
    int tick_len, len, cnt;
    if (!cfg_enable) begin
      m_out = m_pol; m_pe = 1'b0; m_pend = 1'b0; m_pos = 0;
      model_load();
    end else begin
      tick_len = m_pre + 1;
      len = tick_len * (m_per + 1);
      cnt = m_pos / tick_len;
      for (int i = 0; i < NUM_CH; i++) m_out[i] = (m_en[i] && (cnt < m_duty[i])) ^ m_pol[i];
      m_pe = (m_pos == len - 1);
      if (m_pe) begin
        m_pos = 0;
        if (m_pend || cfg_update) model_load();
        m_pend = 1'b0;
      end else begin
        m_pos++;
        m_pend = m_pend || cfg_update;
      end
    end
  endtask

  // ---------------- driver tasks
  task automatic drive_cfg();
    cfg_enable   = nx_enable;
    cfg_prescale = PRE_W'(nx_pre);
    cfg_period   = CNT_W'(nx_per);
    for (int i = 0; i < NUM_CH; i++) cfg_duty[i*CNT_W +: CNT_W] = CNT_W'(nx_duty[i]);
    cfg_ch_en    = nx_en;
    cfg_polarity = nx_pol;
  endtask

  task automatic set_nx(input int pre, input int per, input int d0, input int d1,
                        input int d2, input int d3, input logic [3:0] en, input logic [3:0] pol);
    nx_pre = pre; nx_per = per;
    nx_duty[0] = d0; nx_duty[1] = d1; nx_duty[2] = d2; nx_duty[3] = d3;
    nx_en = en; nx_pol = pol;
  endtask

  task automatic rand_cfg();
    nx_pre = $urandom_range(0, 3);
    nx_per = $urandom_range(0, 12);
    for (int i = 0; i < NUM_CH; i++) nx_duty[i] = $urandom_range(0, 15);
    nx_en  = NUM_CH'($urandom_range(0, 15));
    nx_pol = NUM_CH'($urandom_range(0, 15));
  endtask

  // Sample and check this cycle, then drive this cycle's inputs.
  task automatic tick_cycle(input bit apply, input bit upd);
    @(negedge clk);
    s_out = pwm_out; s_pe = period_end; s_pend = update_pending;
    chk("model pwm_out", 32'(s_out), 32'(m_out));
    chk("model period_end", 32'(s_pe), 32'(m_pe));
    chk("model update_pending", 32'(s_pend), 32'(m_pend));
    if (apply) drive_cfg();
    cfg_update = upd;
    model_step();
  endtask

  task automatic release_reset();
    nx_enable = 1'b0;
    drive_cfg();
    cfg_update = 1'b0;
    rst_n = 1'b1;
    model_reset();
    model_step();
  endtask

  // ---------------- vector table: one full period per row
  typedef struct packed {
    logic [7:0]              pre;
    logic [15:0]             per;
    logic [NUM_CH-1:0][15:0] duty;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       pol;
    logic [NUM_CH-1:0][15:0] exp_high;
    logic [15:0]             exp_len;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int hi [NUM_CH];
    int npe, first_pe, len, n, r, hi_a, hi_b;
    logic p3, p9, p10, any_pend;
    bit u;

    vecs[0] = '{pre: 8'd0, per: 16'd9, duty: {16'd0, 16'd0, 16'd0, 16'd3},
                en: 4'b1111, pol: 4'b0000, exp_high: {16'd0, 16'd0, 16'd0, 16'd3}, exp_len: 16'd10};
    vecs[1] = '{pre: 8'd1, per: 16'd3, duty: {16'd2, 16'd2, 16'd2, 16'd2},
                en: 4'b0001, pol: 4'b0000, exp_high: {16'd0, 16'd0, 16'd0, 16'd4}, exp_len: 16'd8};
    vecs[2] = '{pre: 8'd0, per: 16'd7, duty: {16'd0, 16'd7, 16'd8, 16'd0},
                en: 4'b1111, pol: 4'b1000, exp_high: {16'd8, 16'd7, 16'd8, 16'd0}, exp_len: 16'd8};
    vecs[3] = '{pre: 8'd2, per: 16'd4, duty: {16'd65535, 16'd3, 16'd5, 16'd1},
                en: 4'b1111, pol: 4'b0101, exp_high: {16'd15, 16'd6, 16'd15, 16'd12}, exp_len: 16'd15};
    vecs[4] = '{pre: 8'd3, per: 16'd0, duty: {16'd1, 16'd1, 16'd0, 16'd1},
                en: 4'b1011, pol: 4'b0000, exp_high: {16'd4, 16'd0, 16'd0, 16'd4}, exp_len: 16'd4};

    // ---------------- reset
    model_reset();
    set_nx(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    #12;
    chk("reset pwm_out", 32'(pwm_out), 32'd0);
    chk("reset period_end", 32'(period_end), 32'd0);
    chk("reset update_pending", 32'(update_pending), 32'd0);
    @(negedge clk);
    release_reset();
    for (int k = 0; k < 3; k++) tick_cycle(0, 0);

    // ---------------- table-driven periods
    for (int row = 0; row < 5; row++) begin
      nx_enable = 1'b0;
      nx_pre = int'(vecs[row].pre); nx_per = int'(vecs[row].per);
      for (int i = 0; i < NUM_CH; i++) nx_duty[i] = int'(vecs[row].duty[i]);
      nx_en = vecs[row].en; nx_pol = vecs[row].pol;
      tick_cycle(1, 0); tick_cycle(0, 0); tick_cycle(0, 0);
      nx_enable = 1'b1;
      tick_cycle(1, 0);
      len = int'(vecs[row].exp_len);
      npe = 0; first_pe = -1;
      for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
      for (int j = 1; j <= len; j++) begin
        tick_cycle(0, 0);
        for (int i = 0; i < NUM_CH; i++) if (s_out[i]) hi[i]++;
        if (s_pe) begin
          npe++;
          if (first_pe < 0) first_pe = j;
        end
      end
      for (int i = 0; i < NUM_CH; i++)
        chk($sformatf("vec%0d ch%0d high clocks", row, i), 32'(hi[i]), 32'(vecs[row].exp_high[i]));
      chk($sformatf("vec%0d period_end count", row), 32'(npe), 32'd1);
      chk($sformatf("vec%0d period_end cycle", row), 32'(first_pe), 32'(len));
      nx_enable = 1'b0;
      tick_cycle(1, 0);
    end

    // ---------------- update mid-period, two strobes coalesce
    set_nx(0, 9, 3, 0, 0, 0, 4'b0001, 4'b0000);
    nx_enable = 1'b0; tick_cycle(1, 0); tick_cycle(0, 0);
    nx_enable = 1'b1; tick_cycle(1, 0);
    hi_a = 0; hi_b = 0; p3 = 1'b0; p9 = 1'b0; p10 = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      u = 1'b0;
      if (m == 2) begin nx_duty[0] = 5; u = 1'b1; end
      if (m == 4) begin nx_duty[0] = 7; u = 1'b1; end
      tick_cycle(u, u);
      if (m == 3) p3 = s_pend;
      if (m == 9) p9 = s_pend;
      if (m == 10) p10 = s_pend;
      if (m <= 10) hi_a += int'(s_out[0]);
      else hi_b += int'(s_out[0]);
    end
    chk("mid update pending after strobe", 32'(p3), 32'd1);
    chk("mid update pending at wrap", 32'(p9), 32'd1);
    chk("mid update pending cleared", 32'(p10), 32'd0);
    chk("mid update old period high", 32'(hi_a), 32'd3);
    chk("mid update new period high", 32'(hi_b), 32'd7);
    nx_enable = 1'b0; tick_cycle(1, 0);

    // ---------------- update coincident with the wrap tick
    set_nx(0, 9, 3, 0, 0, 0, 4'b0001, 4'b0000);
    nx_enable = 1'b0; tick_cycle(1, 0); tick_cycle(0, 0);
    nx_enable = 1'b1; tick_cycle(1, 0);
    hi_a = 0; hi_b = 0; any_pend = 1'b0;
    for (int m = 1; m <= 20; m++) begin
      u = 1'b0;
      if (m == 9) begin nx_duty[0] = 6; u = 1'b1; end
      tick_cycle(u, u);
      any_pend = any_pend | s_pend;
      if (m <= 10) hi_a += int'(s_out[0]);
      else hi_b += int'(s_out[0]);
    end
    chk("wrap update pending never", 32'(any_pend), 32'd0);
    chk("wrap update old period high", 32'(hi_a), 32'd3);
    chk("wrap update new period high", 32'(hi_b), 32'd6);
    nx_enable = 1'b0; tick_cycle(1, 0);

    // ---------------- asynchronous reset mid-period
    set_nx(0, 9, 8, 0, 0, 0, 4'b0011, 4'b0010);
    nx_enable = 1'b0; tick_cycle(1, 0); tick_cycle(0, 0);
    nx_enable = 1'b1; tick_cycle(1, 0);
    for (int m = 1; m <= 5; m++) tick_cycle(0, 0);
    chk("pre-reset pwm_out", 32'(s_out), 32'h3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async reset pwm_out", 32'(pwm_out), 32'd0);
    chk("async reset period_end", 32'(period_end), 32'd0);
    chk("async reset update_pending", 32'(update_pending), 32'd0);
    @(negedge clk);
    chk("held reset pwm_out", 32'(pwm_out), 32'd0);
    release_reset();
    for (int k = 0; k < 3; k++) tick_cycle(0, 0);
    chk("post-reset idle pwm_out", 32'(s_out), 32'h2);
    chk("post-reset idle period_end", 32'(s_pe), 32'd0);
    for (int k = 0; k < 8; k++) tick_cycle(0, 0);

    // ---------------- randomized traffic
    for (int it = 0; it < 12; it++) begin
      rand_cfg();
      nx_enable = 1'b0; tick_cycle(1, 0); tick_cycle(0, 0);
      nx_enable = 1'b1; tick_cycle(1, 0);
      n = $urandom_range(60, 160);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 15);
        if (r == 0) begin
          rand_cfg();
          tick_cycle(1, 1);
        end else if (r == 1) begin
          nx_enable = 1'b0; tick_cycle(1, 0);
          nx_enable = 1'b1; tick_cycle(1, 0);
        end else begin
          tick_cycle(0, 0);
        end
      end
      nx_enable = 1'b0; tick_cycle(1, 0);
    end
    tick_cycle(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
